jtpang_busarb: RTL
==================

# jtpang_busarb

Bus arbiter that answers the object DMA bus request on behalf of the CPU. It waits for the CPU's current memory cycle to finish, then freezes the CPU and grants the VRAM bus. While the grant lasts, it steers the VRAM address to the DMA engine. It sits between the CPU core, the CPU-side VRAM decoder and the video block's `busrq`/`busak_n`/`dma_addr` interface.

## Interface
Parameters:
- `DMA_PAGE`, 3'b111: upper three VRAM address bits driven during a DMA grant; the object table sits at 0xE00–0xFFF.
- `TIMEOUT`, 10'd1023: clk cycles in GRANT before a forced release. Used only with the timeout feature.

Ports:
- `clk` in 1: system clock, 48 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_cen` in 1: CPU clock enable.
- `cpu_mreq_n` in 1: CPU memory request, active low.
- `cpu_wr_n` in 1: CPU write strobe, active low.
- `vram_cs` in 1: CPU VRAM chip select.
- `cpu_addr` in 12: CPU VRAM address.
- `busrq` in 1: DMA bus request, active high.
- `dma_addr` in 9: DMA read address.
- `busak_n` out 1: bus acknowledge, active low, registered.
- `cpu_hold` out 1: CPU stall; the parent gates `cpu_cen` with it. Registered.
- `vram_addr` out 12: muxed VRAM address.
- `vram_we` out 1: VRAM write enable.
- `timeout` out 1: sticky forced-release flag.

## Operation
- The FSM has four states: IDLE, DRAIN, GRANT, RELEASE. Encoding is free; the state is visible only through the outputs.
- IDLE:
  - `busak_n`=1, `cpu_hold`=0.
  - `busrq`=1 at a clk edge moves to DRAIN.
- DRAIN:
  - `busrq`=0 returns to IDLE; no grant is issued.
  - An edge with `cpu_cen`=1 and `cpu_mreq_n`=1 moves to GRANT and sets `busak_n`=0, `cpu_hold`=1 at that same edge.
  - `busrq` falling and the grant condition at the same edge: the abort wins.
- GRANT:
  - `busak_n`=0, `cpu_hold`=1.
  - `busrq`=0 moves to RELEASE and sets `busak_n`=1 at that edge.
- RELEASE:
  - `busak_n`=1, `cpu_hold`=1.
  - The first edge with `cpu_cen`=1 clears `cpu_hold` and moves to IDLE.
  - `busrq` is ignored in this state; if it is still high in IDLE, the next request starts the following cycle.
- Address mux (combinational):
  - `busak_n`=0: `vram_addr`={`DMA_PAGE`,`dma_addr`}.
  - Otherwise: `vram_addr`=`cpu_addr`.
- Write enable:
  - `vram_we` = `busak_n` & `vram_cs` & ~`cpu_wr_n` & ~`cpu_mreq_n`.
  - DMA only reads, so writes are always blocked during a grant.
- A reset in any state returns to IDLE immediately. The held CPU is released asynchronously with it.

## Timing
- Reset values: `busak_n`=1, `cpu_hold`=0, `timeout`=0, state IDLE. `vram_addr` follows `cpu_addr`; `vram_we` follows its inputs.
- Minimum `busrq`↑ → `busak_n`↓ latency is 2 clk: one edge to DRAIN, one edge to GRANT when `cpu_cen`=1 and `cpu_mreq_n`=1.
- Latency grows with each `cpu_cen` edge on which `cpu_mreq_n`=0.
- `busrq`↓ → `busak_n`↑ latency: 1 clk.
- `busak_n`↑ → `cpu_hold`↓ latency: up to the next `cpu_cen`, at least 1 clk.
- `cpu_hold` is never low while `busak_n` is low.
- `vram_addr` switches in the same cycle as `busak_n`, with no glitch on the registered edge.

## Configuration
- Macro `JTPANG_BUSARB_TIMEOUT_EN`.
- When defined:
  - A 10-bit counter clears on GRANT entry and increments each clk in GRANT.
  - When it reaches `TIMEOUT`, the FSM moves to RELEASE regardless of `busrq` and sets `timeout`=1.
  - `timeout` stays high until `rst`.
  - After a forced release, a still-high `busrq` is served again via IDLE → DRAIN.
- When undefined: no counter, `timeout` tied 0, GRANT leaves only on `busrq`=0.

## Test plan
- Reset values: `rst`=1 mid-GRANT → `busak_n`=1 and `cpu_hold`=0 immediately; `timeout`=0.
- Basic grant: `cpu_cen` always 1, `cpu_mreq_n`=1, raise `busrq` → `busak_n`↓ 2 clk later.
  - `dma_addr`=9'h1A5 gives `vram_addr`=12'hFA5.
  - Drop `busrq` → `busak_n`↑ 1 clk later; `cpu_hold`↓ 1 clk after that.
- Drain: `cpu_mreq_n`=0 for 3 `cpu_cen` pulses (cen every 6 clk) → no grant until the first cen with `mreq_n`=1.
  - A CPU write with `vram_cs`=1 during DRAIN → `vram_we`=1 with `cpu_addr` passed through.
- Abort: `busrq` pulsed 1 clk while `cpu_mreq_n`=0 → return to IDLE; `busak_n` never goes low.
- Write block: during GRANT, `vram_cs`=1, `cpu_wr_n`=0, `cpu_mreq_n`=0 → `vram_we`=0.
- Timeout (macro on, `TIMEOUT`=16): hold `busrq`=1 → `busak_n`↑ 16 clk after grant, `timeout`=1; a new grant follows via IDLE → DRAIN.

Source files
------------

// File: rtl/jtpang_busarb.sv
// Object-DMA bus arbiter: drains the CPU cycle, freezes the CPU, grants VRAM (busrq->busak_n >= 2 clk).
// CPU is stalled via cpu_hold until a cpu_cen after release; optional GRANT timeout via JTPANG_BUSARB_TIMEOUT_EN.
module jtpang_busarb #(
  parameter logic [2:0] DMA_PAGE = 3'b111,
  parameter logic [9:0] TIMEOUT  = 10'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cen,
  input  logic        cpu_mreq_n,
  input  logic        cpu_wr_n,
  input  logic        vram_cs,
  input  logic [11:0] cpu_addr,
  input  logic        busrq,
  input  logic [8:0]  dma_addr,
  output logic        busak_n,
  output logic        cpu_hold,
  output logic [11:0] vram_addr,
  output logic        vram_we,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  state_t state;
  logic   tout_hit;

`ifdef JTPANG_BUSARB_TIMEOUT_EN
  logic [9:0] cnt;
  logic       tmo_q;

  // Compare against the next count so the release edge lands TIMEOUT clocks after grant.
  assign tout_hit = (cnt + 10'd1) == TIMEOUT;
  assign timeout  = tmo_q;
`else
  logic unused_timeout_param;

  assign unused_timeout_param = ^TIMEOUT;
  assign tout_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busak_n  <= 1'b1;
      cpu_hold <= 1'b0;
`ifdef JTPANG_BUSARB_TIMEOUT_EN
      cnt      <= 10'd0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (busrq) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // An abort on the same edge as the grant condition takes priority.
          if (!busrq) begin
            state <= ST_IDLE;
          end else if (cpu_cen && cpu_mreq_n) begin
            state    <= ST_GRANT;
            busak_n  <= 1'b0;
            cpu_hold <= 1'b1;
`ifdef JTPANG_BUSARB_TIMEOUT_EN
            cnt      <= 10'd0;
`endif
          end
        end
        ST_GRANT: begin
`ifdef JTPANG_BUSARB_TIMEOUT_EN
          cnt <= cnt + 10'd1;
          if (busrq && tout_hit) tmo_q <= 1'b1;
`endif
          if (!busrq || tout_hit) begin
            state   <= ST_RELEASE;
            busak_n <= 1'b1;
          end
        end
        ST_RELEASE: begin
          // The CPU resumes only on its own clock enable; busrq waits for IDLE.
          if (cpu_cen) begin
            state    <= ST_IDLE;
            cpu_hold <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busak_n  <= 1'b1;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  assign vram_addr = busak_n ? cpu_addr : {DMA_PAGE, dma_addr};
  assign vram_we   = busak_n & vram_cs & ~cpu_wr_n & ~cpu_mreq_n;

endmodule
